de_issue_ctrl: RTL and testbench

- Issue/hazard controller between the decode (DE) and address-generation (AG) stages.
- Keeps a per-register scoreboard of in-flight register writes and a count of in-flight memory writes.
- From these it generates reg_dep, mem_dep, ld_ag and ag_vin for the DE→AG handshake.
- Retire feedback from WB releases scoreboard entries; a pipeline flush resets all tracking.

---
 rtl/de_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_de_issue_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/de_issue_ctrl.sv
// de_issue_ctrl
//   Issue/hazard controller between decode (DE) and address generation (AG).
//   Tracks in-flight register writes in a per-register scoreboard of small
//   counters and in-flight memory writes in a single counter, and from these
//   produces the DE->AG handshake (reg_dep, mem_dep, ld_ag, ag_vin).
//   WB retire feedback releases entries; a flush clears all tracking.
//
// Build option:
//   SB_BYPASS_EN  when defined, a same-cycle WB retire that drops a source
//                 counter (or the store counter) from 1 to 0 is forwarded so
//                 the DE instruction does not stall for that hazard.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   de_v                       DE holds a valid instruction
//   de_src1/2, de_src1_v/2_v   DE source registers and their read enables
//   de_dst, de_dst_we          DE destination register and write enable
//   de_re, de_we               DE instruction reads / writes memory
//   mr_stall, mw_stall         memory read / write port stalls
//   wb_v, wb_dst, wb_dst_we    WB retire and its register write
//   wb_mw                      a memory write completed this cycle
//   flush                      pipeline flush (taken jump)
//   reg_dep, mem_dep           register / memory hazard on the DE instruction
//   ld_ag, ag_vin              AG latch enable, valid into AG
//   sb_busy                    per-register nonzero-counter flags
//   st_pend                    in-flight memory writes
//   stall_cnt                  saturating count of stalled DE cycles
module de_issue_ctrl #(
  parameter int NREG        = 8,
  parameter int SB_CNT_W    = 2,
  parameter int ST_CNT_W    = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   de_v,
  input  logic [2:0]             de_src1,
  input  logic [2:0]             de_src2,
  input  logic                   de_src1_v,
  input  logic                   de_src2_v,
  input  logic [2:0]             de_dst,
  input  logic                   de_dst_we,
  input  logic                   de_re,
  input  logic                   de_we,
  input  logic                   mr_stall,
  input  logic                   mw_stall,
  input  logic                   wb_v,
  input  logic [2:0]             wb_dst,
  input  logic                   wb_dst_we,
  input  logic                   wb_mw,
  input  logic                   flush,
  output logic                   reg_dep,
  output logic                   mem_dep,
  output logic                   ld_ag,
  output logic                   ag_vin,
  output logic [NREG-1:0]        sb_busy,
  output logic [ST_CNT_W-1:0]    st_pend,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t              state;
  logic [SB_CNT_W-1:0] cnt [NREG];
  logic                wb_ret;
  logic                s1_busy, s2_busy, dst_full;
  logic                st_busy, st_full;
  logic                issue;
  logic [NREG-1:0]     sb_inc, sb_dec;
  logic                st_inc, st_dec;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

  assign wb_ret = wb_v & wb_dst_we;

  always_comb begin
    s1_busy  = (cnt[de_src1] != '0);
    s2_busy  = (cnt[de_src2] != '0);
    st_busy  = (st_pend != '0);
`ifdef SB_BYPASS_EN
    // A retire that empties the counter this cycle forwards its result.
    if (wb_ret && (wb_dst == de_src1) && (cnt[de_src1] == SB_CNT_W'(1)))
      s1_busy = 1'b0;
    if (wb_ret && (wb_dst == de_src2) && (cnt[de_src2] == SB_CNT_W'(1)))
      s2_busy = 1'b0;
    if (wb_mw && (st_pend == ST_CNT_W'(1)))
      st_busy = 1'b0;
`endif
    // The destination guard stays on registered values: it protects the
    // counter from wrapping, not a data dependency.
    dst_full = (cnt[de_dst] == '1);
    st_full  = (st_pend == '1);
  end

  assign reg_dep = de_v & ((de_src1_v & s1_busy) | (de_src2_v & s2_busy) |
                           (de_dst_we & dst_full));
  assign mem_dep = de_v & ((de_re & st_busy) | (de_we & st_full));
  assign ld_ag   = ~(mem_dep | mr_stall | mw_stall);
  assign ag_vin  = de_v & ~reg_dep & (state == RUN);
  assign issue   = ld_ag & ag_vin;

  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    for (int r = 0; r < NREG; r++) begin
      sb_inc[r]  = issue & de_dst_we & (de_dst == 3'(r));
      // Retiring a register with no pending write is ignored.
      sb_dec[r]  = wb_ret & (wb_dst == 3'(r)) & (cnt[r] != '0);
      sb_busy[r] = (cnt[r] != '0);
    end
  end

  assign st_inc = issue & de_we & ~st_full;
  assign st_dec = wb_mw & (st_pend != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      st_pend   <= '0;
      stall_cnt <= '0;
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      if (de_v && !issue) stall_cnt <= sat_inc(stall_cnt);

      state <= flush ? FLUSH : RUN;

      // Entering or sitting in FLUSH wipes all tracking; anything issued or
      // retired in that cycle belongs to the squashed path.
      if (flush || state == FLUSH) begin
        st_pend <= '0;
        for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
        if (st_inc && !st_dec)      st_pend <= st_pend + ST_CNT_W'(1);
        else if (st_dec && !st_inc) st_pend <= st_pend - ST_CNT_W'(1);
        for (int r = 0; r < NREG; r++) begin
          if (sb_inc[r] && !sb_dec[r])      cnt[r] <= cnt[r] + SB_CNT_W'(1);
          else if (sb_dec[r] && !sb_inc[r]) cnt[r] <= cnt[r] - SB_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_de_issue_ctrl.sv
module tb_de_issue_ctrl;

`ifdef SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        de_v, de_src1_v, de_src2_v, de_dst_we, de_re, de_we;
  logic [2:0]  de_src1, de_src2, de_dst, wb_dst;
  logic        mr_stall, mw_stall, wb_v, wb_dst_we, wb_mw, flush;
  logic        reg_dep, mem_dep, ld_ag, ag_vin;
  logic [7:0]  sb_busy;
  logic [2:0]  st_pend;
  logic [15:0] stall_cnt;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign flags = {reg_dep, mem_dep, ld_ag, ag_vin};

  de_issue_ctrl dut (
    .clk(clk), .reset(reset), .de_v(de_v),
    .de_src1(de_src1), .de_src2(de_src2), .de_src1_v(de_src1_v), .de_src2_v(de_src2_v),
    .de_dst(de_dst), .de_dst_we(de_dst_we), .de_re(de_re), .de_we(de_we),
    .mr_stall(mr_stall), .mw_stall(mw_stall),
    .wb_v(wb_v), .wb_dst(wb_dst), .wb_dst_we(wb_dst_we), .wb_mw(wb_mw), .flush(flush),
    .reg_dep(reg_dep), .mem_dep(mem_dep), .ld_ag(ld_ag), .ag_vin(ag_vin),
    .sb_busy(sb_busy), .st_pend(st_pend), .stall_cnt(stall_cnt)
  );

  // A retire must never target a register with no pending write.
  always @(negedge clk) begin
    if (!reset && wb_v && wb_dst_we && !sb_busy[wb_dst]) begin
      n_fail++;
      $display("FAIL retire_at_zero: reg %0d retired with sb_busy=%h", wb_dst, sb_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    de_v = 0; de_src1 = 0; de_src2 = 0; de_src1_v = 0; de_src2_v = 0;
    de_dst = 0; de_dst_we = 0; de_re = 0; de_we = 0;
    mr_stall = 0; mw_stall = 0;
    wb_v = 0; wb_dst = 0; wb_dst_we = 0; wb_mw = 0; flush = 0;
  endtask

  task automatic test_reset();
    clr(); reset = 1; de_v = 1; mr_stall = 1;
    tick(); tick(); #2;
    n_tests++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL rst_flags: got %b want %b", flags, 4'b0001); end
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL rst_sb_busy: got %h want 00", sb_busy); end
    n_tests++; if (st_pend !== 3'd0) begin n_fail++; $display("FAIL rst_st_pend: got %0d want 0", st_pend); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    tick(); reset = 0; clr(); #2;
    n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL rst_idle_flags: got %b want %b", flags, 4'b0010); end
  endtask

  task automatic test_reg_hazard();
    tick();
    de_v = 1; de_dst = 0; de_dst_we = 1; #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL reg_issue: got %b want %b", flags, 4'b0011); end
    tick();
    clr(); de_v = 1; de_src1 = 0; de_src1_v = 1; wb_v = 1; wb_dst = 0; wb_dst_we = 1; #2;
    n_tests++; if (sb_busy !== 8'h01) begin n_fail++; $display("FAIL reg_sb_busy: got %h want 01", sb_busy); end
    n_tests++; if (flags !== (BYP ? 4'b0011 : 4'b1010)) begin n_fail++; $display("FAIL reg_wb_cycle: got %b want %b", flags, (BYP ? 4'b0011 : 4'b1010)); end
    tick();
    clr(); de_v = 1; de_src1 = 0; de_src1_v = 1; #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL reg_after_wb: got %b want %b", flags, 4'b0011); end
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL reg_sb_clear: got %h want 00", sb_busy); end
    n_tests++; if (stall_cnt !== (BYP ? 16'd0 : 16'd1)) begin n_fail++; $display("FAIL reg_stall_cnt: got %0d want %0d", stall_cnt, (BYP ? 0 : 1)); end
    tick();
    clr(); de_v = 1; de_dst = 5; de_dst_we = 1;
    tick();
    clr(); de_v = 1; de_src2 = 5; de_src2_v = 1; de_src1 = 0; de_src1_v = 1; #2;
    n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL reg_src2: got %b want %b", flags, 4'b1010); end
    de_v = 0; #1;
    n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL reg_no_valid: got %b want %b", flags, 4'b0010); end
    tick();
    clr(); wb_v = 1; wb_dst = 5; wb_dst_we = 1;
    tick();
    clr(); #2;
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL reg_src2_release: got %h want 00", sb_busy); end
  endtask

  task automatic test_mem_hazard();
    tick();
    clr(); de_v = 1; de_we = 1; #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL mem_store: got %b want %b", flags, 4'b0011); end
    tick();
    clr(); de_v = 1; de_re = 1; #2;
    n_tests++; if (st_pend !== 3'd1) begin n_fail++; $display("FAIL mem_st_pend1: got %0d want 1", st_pend); end
    n_tests++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL mem_load_wait: got %b want %b", flags, 4'b0101); end
    tick();
    wb_mw = 1; #2;
    n_tests++; if (flags !== (BYP ? 4'b0011 : 4'b0101)) begin n_fail++; $display("FAIL mem_wb_cycle: got %b want %b", flags, (BYP ? 4'b0011 : 4'b0101)); end
    tick();
    clr(); de_v = 1; de_re = 1; #2;
    n_tests++; if (st_pend !== 3'd0) begin n_fail++; $display("FAIL mem_st_pend0: got %0d want 0", st_pend); end
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL mem_load_go: got %b want %b", flags, 4'b0011); end
    tick();
    clr(); de_v = 1; mw_stall = 1; #2;
    n_tests++; if (flags !== 4'b0001) begin n_fail++; $display("FAIL mem_mw_stall: got %b want %b", flags, 4'b0001); end
    tick();
    clr(); de_v = 1; de_we = 1;
    repeat (7) tick();
    #2;
    n_tests++; if (st_pend !== 3'd7) begin n_fail++; $display("FAIL mem_st_full: got %0d want 7", st_pend); end
    n_tests++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL mem_store_held: got %b want %b", flags, 4'b0101); end
    wb_mw = 1;
    tick(); #2;
    n_tests++; if (st_pend !== 3'd6) begin n_fail++; $display("FAIL mem_st_dec: got %0d want 6", st_pend); end
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL mem_store_go: got %b want %b", flags, 4'b0011); end
    tick(); #2;
    n_tests++; if (st_pend !== 3'd6) begin n_fail++; $display("FAIL mem_st_both: got %0d want 6", st_pend); end
    clr(); wb_mw = 1;
    repeat (6) tick();
    clr(); #2;
    n_tests++; if (st_pend !== 3'd0) begin n_fail++; $display("FAIL mem_st_drain: got %0d want 0", st_pend); end
  endtask

  task automatic test_overflow();
    tick();
    clr(); de_v = 1; de_dst = 1; de_dst_we = 1;
    repeat (3) tick();
    #2;
    n_tests++; if (sb_busy !== 8'h02) begin n_fail++; $display("FAIL ovf_sb_busy: got %h want 02", sb_busy); end
    n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ovf_fourth: got %b want %b", flags, 4'b1010); end
    wb_v = 1; wb_dst = 1; wb_dst_we = 1; #1;
    n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ovf_guard_wb: got %b want %b", flags, 4'b1010); end
    tick(); #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL ovf_at2: got %b want %b", flags, 4'b0011); end
    tick();
    wb_v = 0; wb_dst_we = 0; #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL ovf_both_kept2: got %b want %b", flags, 4'b0011); end
    tick(); #2;
    n_tests++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL ovf_back_to3: got %b want %b", flags, 4'b1010); end
    clr(); wb_v = 1; wb_dst = 1; wb_dst_we = 1;
    tick(); tick(); tick();
    clr(); #2;
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL ovf_drain: got %h want 00", sb_busy); end
  endtask

  task automatic test_flush();
    tick();
    clr(); reset = 1;
    tick();
    reset = 0; de_v = 1; de_dst = 0; de_dst_we = 1;
    tick();
    de_dst = 2;
    tick();
    de_dst_we = 0; de_we = 1;
    tick(); tick();
    clr(); #2;
    n_tests++; if (sb_busy !== 8'h05) begin n_fail++; $display("FAIL fl_pre_busy: got %h want 05", sb_busy); end
    n_tests++; if (st_pend !== 3'd2) begin n_fail++; $display("FAIL fl_pre_st: got %0d want 2", st_pend); end
    flush = 1; de_v = 1; de_dst = 3; de_dst_we = 1; de_we = 1;
    wb_v = 1; wb_dst = 0; wb_dst_we = 1;
    tick();
    wb_v = 0; wb_dst_we = 0; #2;
    n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL fl_cycle1: got %b want %b", flags, 4'b0010); end
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL fl_busy_clr: got %h want 00", sb_busy); end
    n_tests++; if (st_pend !== 3'd0) begin n_fail++; $display("FAIL fl_st_clr: got %0d want 0", st_pend); end
    tick();
    flush = 0; #2;
    n_tests++; if (flags !== 4'b0010) begin n_fail++; $display("FAIL fl_held: got %b want %b", flags, 4'b0010); end
    tick(); #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL fl_run: got %b want %b", flags, 4'b0011); end
    n_tests++; if (sb_busy !== 8'h00) begin n_fail++; $display("FAIL fl_run_busy: got %h want 00", sb_busy); end
    n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL fl_stall_kept: got %0d want 2", stall_cnt); end
    tick();
    clr(); de_v = 1; reset = 1; flush = 1; #2;
    n_tests++; if (sb_busy !== 8'h08) begin n_fail++; $display("FAIL midrst_pre_busy: got %h want 08", sb_busy); end
    n_tests++; if (st_pend !== 3'd1) begin n_fail++; $display("FAIL midrst_pre_st: got %0d want 1", st_pend); end
    tick();
    reset = 0; flush = 0; #2;
    n_tests++; if (flags !== 4'b0011) begin n_fail++; $display("FAIL midrst_flags: got %b want %b", flags, 4'b0011); end
    n_tests++; if ({sb_busy, st_pend} !== 11'd0) begin n_fail++; $display("FAIL midrst_state: got %h/%0d want 00/0", sb_busy, st_pend); end
    n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_stall_sat();
    tick();
    clr(); reset = 1;
    tick();
    reset = 0; de_v = 1; mr_stall = 1;
    repeat (65534) tick();
    #2;
    n_tests++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h want FFFE", stall_cnt); end
    repeat (4466) tick();
    #2;
    n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want FFFF", stall_cnt); end
  endtask

  initial begin
    clr(); reset = 1;
    test_reset();
    test_reg_hazard();
    test_mem_hazard();
    test_overflow();
    test_flush();
    test_stall_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
